// File: rtl/id_pipe_pkg.sv
// Shared types for the decode-to-execute pipeline register: field widths,
// skid-buffer state encoding and the packed decode bundle.
package id_pipe_pkg;

  localparam int ID_ADDRESS_LEN          = 32;
  localparam int ID_REGISTER_LEN         = 32;
  localparam int ID_REG_ADDRESS_LEN      = 4;
  localparam int ID_EXECUTE_COMMAND_LEN  = 4;
  localparam int ID_SIGNED_IMMEDIATE_LEN = 24;
  localparam int ID_SHIFT_OPERAND_LEN    = 12;
  localparam int ID_STALL_CNT_W          = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [ID_ADDRESS_LEN-1:0]          pc;
    logic                               mem_read_en;
    logic                               mem_write_en;
    logic                               wb_enable;
    logic                               immediate;
    logic                               branch_taken;
    logic                               status_write_enable;
    logic [ID_EXECUTE_COMMAND_LEN-1:0]  execute_command;
    logic [ID_REGISTER_LEN-1:0]         reg_file1;
    logic [ID_REGISTER_LEN-1:0]         reg_file2;
    logic [ID_REG_ADDRESS_LEN-1:0]      dest_reg;
    logic [ID_SIGNED_IMMEDIATE_LEN-1:0] signed_immediate;
    logic [ID_SHIFT_OPERAND_LEN-1:0]    shift_operand;
  } id_bundle_t;

  localparam int ID_BUNDLE_W = $bits(id_bundle_t);

endpackage

// File: rtl/id_stage_pipe_reg_if.sv
// Decode-side and EX-side handshake plus bundle signals of the ID/EX register.
// slave is the register's view; master is the view of the surrounding stage logic.
interface id_stage_pipe_reg_if #(
  parameter int ADDRESS_LEN          = 32,
  parameter int REGISTER_LEN         = 32,
  parameter int REG_ADDRESS_LEN      = 4,
  parameter int EXECUTE_COMMAND_LEN  = 4,
  parameter int SIGNED_IMMEDIATE_LEN = 24,
  parameter int SHIFT_OPERAND_LEN    = 12,
  parameter int STALL_CNT_W          = 16
) ();

  logic                            flush;
  logic                            in_valid;
  logic                            in_ready;
  logic [ADDRESS_LEN-1:0]          PC_in;
  logic                            mem_read_en_in;
  logic                            mem_write_en_in;
  logic                            wb_enable_in;
  logic                            immediate_in;
  logic                            branch_taken_in;
  logic                            status_write_enable_in;
  logic [EXECUTE_COMMAND_LEN-1:0]  execute_command_in;
  logic [REGISTER_LEN-1:0]         reg_file_in1;
  logic [REGISTER_LEN-1:0]         reg_file_in2;
  logic [REG_ADDRESS_LEN-1:0]      dest_reg_in;
  logic [SIGNED_IMMEDIATE_LEN-1:0] signed_immediate_in;
  logic [SHIFT_OPERAND_LEN-1:0]    shift_operand_in;

  logic                            out_valid;
  logic                            out_ready;
  logic [ADDRESS_LEN-1:0]          PC_out;
  logic                            mem_read_en_out;
  logic                            mem_write_en_out;
  logic                            wb_enable_out;
  logic                            immediate_out;
  logic                            branch_taken_out;
  logic                            status_write_enable_out;
  logic [EXECUTE_COMMAND_LEN-1:0]  execute_command_out;
  logic [REGISTER_LEN-1:0]         reg_file_out1;
  logic [REGISTER_LEN-1:0]         reg_file_out2;
  logic [REG_ADDRESS_LEN-1:0]      dest_reg_out;
  logic [SIGNED_IMMEDIATE_LEN-1:0] signed_immediate_out;
  logic [SHIFT_OPERAND_LEN-1:0]    shift_operand_out;

  logic [STALL_CNT_W-1:0]          stall_count;
  logic                            stall_clear;

  modport slave (
    input  flush, in_valid, PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in,
           immediate_in, branch_taken_in, status_write_enable_in, execute_command_in,
           reg_file_in1, reg_file_in2, dest_reg_in, signed_immediate_in,
           shift_operand_in, out_ready, stall_clear,
    output in_ready, out_valid, PC_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out, immediate_out, branch_taken_out, status_write_enable_out,
           execute_command_out, reg_file_out1, reg_file_out2, dest_reg_out,
           signed_immediate_out, shift_operand_out, stall_count
  );

  modport master (
    output flush, in_valid, PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in,
           immediate_in, branch_taken_in, status_write_enable_in, execute_command_in,
           reg_file_in1, reg_file_in2, dest_reg_in, signed_immediate_in,
           shift_operand_in, out_ready, stall_clear,
    input  in_ready, out_valid, PC_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out, immediate_out, branch_taken_out, status_write_enable_out,
           execute_command_out, reg_file_out1, reg_file_out2, dest_reg_out,
           signed_immediate_out, shift_operand_out, stall_count
  );

endinterface

// File: rtl/id_skid_buffer.sv
// Two-entry skid buffer: head (main) entry drives the output, skid entry absorbs
// the one extra beat accepted while in_ready is still registered high.
module id_skid_buffer
  import id_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = ID_BUNDLE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 push, pop;

  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data_i;
          end else if (push) begin
            skid_d  = in_data_i;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_stage_pipe_reg.sv
// ID/EX pipeline register: packs the decode bundle through a skid buffer,
// gates side-effect flags on bubbles and counts EX back-pressure cycles.
module id_stage_pipe_reg
  import id_pipe_pkg::*;
#(
  parameter int ADDRESS_LEN          = ID_ADDRESS_LEN,
  parameter int REGISTER_LEN         = ID_REGISTER_LEN,
  parameter int REG_ADDRESS_LEN      = ID_REG_ADDRESS_LEN,
  parameter int EXECUTE_COMMAND_LEN  = ID_EXECUTE_COMMAND_LEN,
  parameter int SIGNED_IMMEDIATE_LEN = ID_SIGNED_IMMEDIATE_LEN,
  parameter int SHIFT_OPERAND_LEN    = ID_SHIFT_OPERAND_LEN,
  parameter int STALL_CNT_W          = ID_STALL_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  id_stage_pipe_reg_if.slave  bus
);

  localparam int PAYLOAD_W = ADDRESS_LEN + 6 + EXECUTE_COMMAND_LEN + 2 * REGISTER_LEN
                           + REG_ADDRESS_LEN + SIGNED_IMMEDIATE_LEN + SHIFT_OPERAND_LEN;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  id_bundle_t             in_bundle;
  id_bundle_t             head;
  logic [PAYLOAD_W-1:0]   in_w, head_w;
  logic                   out_valid;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign in_bundle.pc                  = bus.PC_in;
  assign in_bundle.mem_read_en         = bus.mem_read_en_in;
  assign in_bundle.mem_write_en        = bus.mem_write_en_in;
  assign in_bundle.wb_enable           = bus.wb_enable_in;
  assign in_bundle.immediate           = bus.immediate_in;
  assign in_bundle.branch_taken        = bus.branch_taken_in;
  assign in_bundle.status_write_enable = bus.status_write_enable_in;
  assign in_bundle.execute_command     = bus.execute_command_in;
  assign in_bundle.reg_file1           = bus.reg_file_in1;
  assign in_bundle.reg_file2           = bus.reg_file_in2;
  assign in_bundle.dest_reg            = bus.dest_reg_in;
  assign in_bundle.signed_immediate    = bus.signed_immediate_in;
  assign in_bundle.shift_operand       = bus.shift_operand_in;
  assign in_w                          = in_bundle;

  id_skid_buffer #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_w),
    .out_valid_o (out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (head_w)
  );

  assign head = head_w;

  // Side-effect flags must read 0 on a bubble so EX cannot act on stale data
  assign bus.out_valid               = out_valid;
  assign bus.PC_out                  = head.pc;
  assign bus.mem_read_en_out         = head.mem_read_en & out_valid;
  assign bus.mem_write_en_out        = head.mem_write_en & out_valid;
  assign bus.wb_enable_out           = head.wb_enable & out_valid;
  assign bus.immediate_out           = head.immediate;
  assign bus.branch_taken_out        = head.branch_taken & out_valid;
  assign bus.status_write_enable_out = head.status_write_enable & out_valid;
  assign bus.execute_command_out     = head.execute_command;
  assign bus.reg_file_out1           = head.reg_file1;
  assign bus.reg_file_out2           = head.reg_file2;
  assign bus.dest_reg_out            = head.dest_reg;
  assign bus.signed_immediate_out    = head.signed_immediate;
  assign bus.shift_operand_out       = head.shift_operand;

  always_comb begin
    stall_d = stall_q;
    if (bus.stall_clear) begin
      stall_d = '0;
    end else if (out_valid && !bus.out_ready) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_id_stage_pipe_reg.sv
// Directed bench for the ID/EX skid register with a scoreboard-based monitor.
module tb_id_stage_pipe_reg;
  import id_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  id_bundle_t exp_q[$];
  id_bundle_t mon_got, mon_exp;
  id_bundle_t idle_b;
  bit         acc;

  always #5 clk = ~clk;

  id_stage_pipe_reg_if #(.STALL_CNT_W(4)) bus ();

  id_stage_pipe_reg #(.STALL_CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void check(input string name, input logic [159:0] act,
                                input logic [159:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic id_bundle_t mk(input logic [31:0] pc);
    id_bundle_t b;
    b.pc                  = pc;
    b.mem_read_en         = pc[2];
    b.mem_write_en        = 1'b1;
    b.wb_enable           = 1'b1;
    b.immediate           = pc[3];
    b.branch_taken        = pc[4];
    b.status_write_enable = 1'b1;
    b.execute_command     = pc[5:2];
    b.reg_file1           = pc ^ 32'hDEAD_0000;
    b.reg_file2           = ~pc;
    b.dest_reg            = pc[3:0] ^ 4'hF;
    b.signed_immediate    = {pc[7:0], 16'h1234};
    b.shift_operand       = {4'hA, pc[7:0]};
    return b;
  endfunction

  function automatic id_bundle_t get_out();
    id_bundle_t b;
    b.pc                  = bus.PC_out;
    b.mem_read_en         = bus.mem_read_en_out;
    b.mem_write_en        = bus.mem_write_en_out;
    b.wb_enable           = bus.wb_enable_out;
    b.immediate           = bus.immediate_out;
    b.branch_taken        = bus.branch_taken_out;
    b.status_write_enable = bus.status_write_enable_out;
    b.execute_command     = bus.execute_command_out;
    b.reg_file1           = bus.reg_file_out1;
    b.reg_file2           = bus.reg_file_out2;
    b.dest_reg            = bus.dest_reg_out;
    b.signed_immediate    = bus.signed_immediate_out;
    b.shift_operand       = bus.shift_operand_out;
    return b;
  endfunction

  task automatic put(input id_bundle_t b);
    bus.PC_in                  = b.pc;
    bus.mem_read_en_in         = b.mem_read_en;
    bus.mem_write_en_in        = b.mem_write_en;
    bus.wb_enable_in           = b.wb_enable;
    bus.immediate_in           = b.immediate;
    bus.branch_taken_in        = b.branch_taken;
    bus.status_write_enable_in = b.status_write_enable;
    bus.execute_command_in     = b.execute_command;
    bus.reg_file_in1           = b.reg_file1;
    bus.reg_file_in2           = b.reg_file2;
    bus.dest_reg_in            = b.dest_reg;
    bus.signed_immediate_in    = b.signed_immediate;
    bus.shift_operand_in       = b.shift_operand;
  endtask

  // One clock of stimulus; returns whether the bundle was accepted.
  task automatic step(input bit v, input id_bundle_t b, input bit ordy, input bit fl,
                      input bit sc, output bit accepted);
    bus.in_valid    = v;
    put(b);
    bus.out_ready   = ordy;
    bus.flush       = fl;
    bus.stall_clear = sc;
    @(negedge clk);
    accepted = v & bus.in_ready;
    if (accepted && !fl) exp_q.push_back(b);
    @(posedge clk);
    if (fl) exp_q.delete();
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      mon_got = get_out();
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected actual_pc=%0h required=no_output", mon_got.pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_bundle", 160'(mon_got), 160'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_b = mk(32'h0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0; bus.stall_clear = 1'b0;
    put(idle_b);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  160'(bus.in_ready), 160'(1));
    check("rst_out_valid", 160'(bus.out_valid), 160'(0));
    check("rst_pc",        160'(bus.PC_out), 160'(0));
    check("rst_stall",     160'(bus.stall_count), 160'(0));
    rst = 1'b1;

    // stream with out_ready high
    step(1, mk(32'h00), 1, 0, 0, acc); check("s0_acc", 160'(acc), 160'(1));
    check("s0_latency_valid", 160'(bus.out_valid), 160'(1));
    check("s0_latency_pc",    160'(bus.PC_out), 160'(32'h00));
    step(1, mk(32'h04), 1, 0, 0, acc); check("s1_acc", 160'(acc), 160'(1));
    step(1, mk(32'h08), 1, 0, 0, acc); check("s2_acc", 160'(acc), 160'(1));
    check("s2_pc", 160'(bus.PC_out), 160'(32'h08));
    step(0, idle_b, 1, 0, 0, acc);
    check("s_drained", 160'(bus.out_valid), 160'(0));
    check("s_stall",   160'(bus.stall_count), 160'(0));

    // back-pressure
    step(1, mk(32'h10), 0, 0, 0, acc); check("bp0_acc", 160'(acc), 160'(1));
    step(1, mk(32'h14), 0, 0, 0, acc); check("bp1_acc", 160'(acc), 160'(1));
    check("bp_full_ready", 160'(bus.in_ready), 160'(0));
    step(1, mk(32'h18), 0, 0, 0, acc); check("bp2_acc", 160'(acc), 160'(0));
    step(1, mk(32'h18), 1, 0, 0, acc); check("bp3_acc", 160'(acc), 160'(0));
    check("bp_ready_rise", 160'(bus.in_ready), 160'(1));
    step(1, mk(32'h18), 1, 0, 0, acc); check("bp4_acc", 160'(acc), 160'(1));
    step(0, idle_b, 1, 0, 0, acc);
    check("bp_stall", 160'(bus.stall_count), 160'(2));

    // flush in TWO (push blocked) then flush in ONE with a real push
    step(1, mk(32'h20), 0, 0, 0, acc);
    step(1, mk(32'h24), 0, 0, 0, acc);
    step(1, mk(32'h28), 0, 1, 0, acc);
    check("fl_valid",    160'(bus.out_valid), 160'(0));
    check("fl_wb",       160'(bus.wb_enable_out), 160'(0));
    check("fl_memwr",    160'(bus.mem_write_en_out), 160'(0));
    check("fl_ready",    160'(bus.in_ready), 160'(1));
    check("fl_pc_hold",  160'(bus.PC_out), 160'(32'h20));
    check("fl_stall",    160'(bus.stall_count), 160'(4));
    step(0, idle_b, 1, 0, 0, acc);
    step(1, mk(32'h30), 1, 0, 0, acc);
    step(1, mk(32'h34), 1, 1, 0, acc);
    check("fl1_valid", 160'(bus.out_valid), 160'(0));
    step(0, idle_b, 1, 0, 0, acc);
    step(0, idle_b, 1, 0, 0, acc);

    // push and pop together in ONE
    step(1, mk(32'h40), 1, 0, 0, acc);
    step(1, mk(32'h44), 1, 0, 0, acc);
    check("pp_valid", 160'(bus.out_valid), 160'(1));
    check("pp_pc",    160'(bus.PC_out), 160'(32'h44));
    check("pp_ready", 160'(bus.in_ready), 160'(1));
    step(0, idle_b, 1, 0, 0, acc);

    // stall counter saturation and clear
    step(1, mk(32'h50), 0, 0, 0, acc);
    for (int i = 0; i < 20; i++) step(0, idle_b, 0, 0, 0, acc);
    check("sat_15", 160'(bus.stall_count), 160'(15));
    step(0, idle_b, 0, 0, 1, acc);
    check("clr_wins", 160'(bus.stall_count), 160'(0));
    step(0, idle_b, 0, 0, 0, acc);
    check("after_clr", 160'(bus.stall_count), 160'(1));
    step(0, idle_b, 1, 0, 0, acc);

    // asynchronous reset while holding two entries
    step(1, mk(32'h60), 0, 0, 0, acc);
    step(1, mk(32'h64), 0, 0, 0, acc);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 160'(bus.out_valid), 160'(0));
    check("ar_ready", 160'(bus.in_ready), 160'(1));
    check("ar_pc",    160'(bus.PC_out), 160'(0));
    check("ar_rf1",   160'(bus.reg_file_out1), 160'(0));
    check("ar_stall", 160'(bus.stall_count), 160'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    step(1, mk(32'h70), 0, 0, 0, acc);
    check("ar_push_pc",    160'(bus.PC_out), 160'(32'h70));
    check("ar_push_ready", 160'(bus.in_ready), 160'(1));
    step(0, idle_b, 1, 0, 0, acc);
    check("ar_sole", 160'(bus.out_valid), 160'(0));

    check("sb_empty", 160'(exp_q.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe_reg.md
# id_stage_pipe_reg

Parametrised decode-to-execute pipeline register that replaces the plain ID/EX latch. It carries the full decoded instruction bundle from the decode logic to the execute stage through a 2-entry skid buffer. The buffer provides valid/ready back-pressure, a synchronous flush that inserts a bubble, and a saturating stall-cycle counter. It sits between the decode logic and the EX stage inside the ID stage wrapper.

## Interface
Parameters:
- ADDRESS_LEN, 32: PC width.
- REGISTER_LEN, 32: register operand width.
- REG_ADDRESS_LEN, 4: destination register index width.
- EXECUTE_COMMAND_LEN, 4: ALU command width.
- SIGNED_IMMEDIATE_LEN, 24: branch immediate width.
- SHIFT_OPERAND_LEN, 12: shifter operand width.
- STALL_CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  decode bundle valid.
- in_ready  out  1  buffer can accept a bundle this cycle.
- PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in, execute_command_in, reg_file_in1, reg_file_in2, dest_reg_in, signed_immediate_in, shift_operand_in  in  per parameters (1-bit flags)  decoded bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EX consumes the head this cycle.
- PC_out … shift_operand_out  out  same widths  head bundle.
- stall_count  out  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0.
- stall_clear  in  1  synchronous clear of stall_count.

## Operation
- Storage: main entry (head) and skid entry. States: EMPTY, ONE, TWO.
- in_ready = (state != TWO). This is a pure function of registered state, with no combinational path from out_ready.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- EMPTY: push → ONE, bundle written to main.
- ONE:
  - push & pop → ONE, main ← new bundle.
  - push only → TWO, skid ← new bundle.
  - pop only → EMPTY.
- TWO:
  - pop → ONE, main ← skid.
  - No push is possible.
- Ordering is strictly FIFO. A bundle is never dropped or duplicated except by flush or reset.
- flush has priority over everything. The next state is EMPTY, and any bundle pushed in the flush cycle is discarded. A pop in the flush cycle still counts as consumed by EX.
- Bubble gating: when out_valid=0, the outputs mem_read_en_out, mem_write_en_out, wb_enable_out, branch_taken_out and status_write_enable_out are forced to 0. The data outputs hold their last value.
- stall_count:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at all-ones.
  - stall_clear wins over an increment in the same cycle.
  - flush does not clear it.

## Timing
- Latency is 1 cycle: a bundle pushed at edge N is presented on the outputs with out_valid=1 after edge N.
- Throughput is 1 bundle per cycle with out_ready held high.
- After one cycle of out_ready=0 the buffer still accepts one more bundle. in_ready drops the cycle after the skid entry fills, and rises the cycle after the first pop from TWO.
- Reset (rst=0), asynchronous and immediate:
  - State becomes EMPTY, so in_ready=1 and out_valid=0.
  - All bundle outputs and stall_count are 0.
  - Reset mid-operation discards both entries without any handshake.
- Reset release is synchronised externally. The first push is allowed on the first edge with rst=1.

## Structure
- Package id_pipe_pkg holds:
  - field-width constants matching the global defines;
  - state enum {EMPTY, ONE, TWO};
  - packed struct id_bundle_t with the fields in port order, and its width constant.
- Sub-module id_skid_buffer, generic over PAYLOAD_W:
  - contains the state machine and both entries;
  - has flush, valid/ready on both sides, and a packed payload.
- The top level:
  - packs and unpacks id_bundle_t;
  - applies bubble gating;
  - owns stall_count.

## Test plan
- Reset then stream: push PC=0x00, 0x04, 0x08 with out_ready=1 → outputs show the PCs 1 cycle later in order, with in_ready constantly 1.
- Back-pressure: out_ready=0 while pushing 0x10, 0x14, 0x18 → first two accepted, in_ready=0 on the third, 0x18 held upstream. Raising out_ready yields 0x10, 0x14, 0x18 in order. stall_count equals the low cycles.
- Flush in TWO with a simultaneous push of wb_enable_in=1 → next cycle out_valid=0, wb_enable_out=0, mem_write_en_out=0, in_ready=1, pushed bundle never appears.
- Push in ONE with simultaneous pop → the state stays ONE and the new bundle is on the outputs the next cycle, with no gap.
- stall_count saturation: STALL_CNT_W=4, hold out_ready=0 for 20 cycles → count stops at 15. Assert stall_clear with a stall → count reads 0.
- Async reset mid-stream in TWO (rst pulsed low between edges) → out_valid, all outputs and stall_count are 0 immediately, and the next push appears as the sole entry.
